// File: rtl/osd_spi_pkg.sv
// osd_spi_pkg: shared types and constants for the OSD SPI transmitter.
//   osd_op_e    - command opcodes accepted on the command port
//   osd_state_e - transmitter FSM states (also exported as a debug output)
//   CMD_*       - OSD command byte values, LINE_LEN - data bytes per line
//   cmd_byte()  - maps an opcode and line number to the first byte on the wire
package osd_spi_pkg;

  typedef enum logic [1:0] {
    OSD_DISABLE = 2'd0,
    OSD_ENABLE  = 2'd1,
    OSD_WRITE   = 2'd2,
    OSD_CLEAR   = 2'd3
  } osd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEL   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DESEL = 2'd3
  } osd_state_e;

  localparam logic [7:0] CMD_DISABLE = 8'h40;
  localparam logic [7:0] CMD_ENABLE  = 8'h41;
  localparam logic [7:0] CMD_LINE    = 8'h20;
  localparam int         LINE_LEN    = 256;

  function automatic logic [7:0] cmd_byte(input osd_op_e op, input logic [2:0] line);
    logic [7:0] b;
    case (op)
      OSD_DISABLE: b = CMD_DISABLE;
      OSD_ENABLE:  b = CMD_ENABLE;
      default:     b = CMD_LINE | {5'b0, line};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/osd_spi_tx_if.sv
// osd_spi_tx_if: command port and line-buffer fetch port of osd_spi_tx.
//   cmd_valid/cmd_ready/cmd_op/cmd_line - command handshake
//   byte_rd/byte_addr/byte_data         - line buffer fetch (data one cycle after byte_rd)
// Handshake: a command transfers on every rising clk_sys edge where
// cmd_valid & cmd_ready are both 1; the master holds cmd_valid, cmd_op and
// cmd_line stable until that edge, and cmd_valid does not depend on cmd_ready.
interface osd_spi_tx_if;
  import osd_spi_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  osd_op_e     cmd_op;
  logic [2:0]  cmd_line;
  logic        byte_rd;
  logic [10:0] byte_addr;
  logic [7:0]  byte_data;

  // master: the core issuing commands and owning the line buffer
  modport master (output cmd_valid, cmd_op, cmd_line, byte_data,
                  input  cmd_ready, byte_rd, byte_addr);
  // slave: the SPI transmitter
  modport slave  (input  cmd_valid, cmd_op, cmd_line, byte_data,
                  output cmd_ready, byte_rd, byte_addr);
endinterface

// File: rtl/osd_spi_byte_tx.sv
// osd_spi_byte_tx: shifts one byte MSB first, CLK_DIV clk_sys cycles per SCK half.
//   en             - advance phase timing (top asserts only while shifting)
//   load/load_data - restart at bit 7 low phase with a new byte (wins over en)
//   sck, di        - raw serial clock and data bit (top gates them by state)
//   last_low_start - first cycle of bit 0's low phase
//   byte_done      - last cycle of bit 0's high phase
module osd_spi_byte_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       sck,
  output logic       di,
  output logic       last_low_start,
  output logic       byte_done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;
  logic       high;
  logic [2:0] bit_cnt;
  logic [7:0] sr;
  logic       phase_end;

  assign phase_end = en && (div_cnt == DIV_LAST);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      high    <= 1'b0;
      bit_cnt <= '0;
      sr      <= '0;
    end else if (load) begin
      sr      <= load_data;
      div_cnt <= '0;
      high    <= 1'b0;
      bit_cnt <= '0;
    end else if (en) begin
      if (phase_end) begin
        div_cnt <= '0;
        if (!high) begin
          high <= 1'b1;
        end else begin
          // end of a bit: next bit's low phase starts with the new DI value;
          // bit_cnt wraps 7 -> 0 so an unloaded finish leaves the shifter idle
          high    <= 1'b0;
          bit_cnt <= bit_cnt + 3'd1;
          sr      <= {sr[6:0], 1'b0};
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

  assign sck            = high;
  assign di             = sr[7];
  assign last_low_start = en && !high && (bit_cnt == 3'd7) && (div_cnt == 8'd0);
  assign byte_done      = high && (bit_cnt == 3'd7) && phase_end;

endmodule

// File: rtl/osd_spi_tx.sv
// osd_spi_tx: SPI master for the OSD overlay link (SCK idles low, SS3 active-low,
// DI changes at the start of each SCK low phase, MSB first).
//   clk_sys, reset_n - clock, asynchronous active-low reset
//   bus (slave)      - command handshake and line-buffer fetch port
//   done             - one-cycle pulse on the first cycle SS3 is high again
//   SPI_SCK/SS3/DI   - serial link
//   state_dbg        - current FSM state
// Optional build macro OSD_SPI_TX_CLEAR_EN: when defined, op 3 streams a line of
// zeros; otherwise op 3 is accepted, sends nothing and only pulses done.
module osd_spi_tx
  import osd_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP     = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  osd_spi_tx_if.slave bus,
  output logic        done,
  output logic        SPI_SCK,
  output logic        SPI_SS3,
  output logic        SPI_DI,
  output osd_state_e  state_dbg
);

  localparam logic [15:0] SEL_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);
  localparam logic [8:0]  LEN9     = 9'(LINE_LEN);

  osd_state_e  state, next_state;
  osd_op_e     op_q;
  logic [2:0]  line_q;
  logic [8:0]  byte_cnt;   // data bytes loaded so far, 0..256, never wraps
  logic [15:0] wait_cnt;
  logic [7:0]  hold_q;
  logic        rd_q;

  logic        load;
  logic [7:0]  load_data;
  logic        tx_en, tx_sck, tx_di, tx_last_low, tx_byte_done;
  logic        has_data, more_bytes, skip_spi, handshake;
  logic [7:0]  data_byte;

`ifdef OSD_SPI_TX_CLEAR_EN
  assign skip_spi  = 1'b0;
  assign has_data  = (op_q == OSD_WRITE) || (op_q == OSD_CLEAR);
  assign data_byte = (op_q == OSD_CLEAR) ? 8'h00 : hold_q;
`else
  // clear without the clear path: handshake goes straight to DESEL for the done pulse
  assign skip_spi  = (bus.cmd_op == OSD_CLEAR);
  assign has_data  = (op_q == OSD_WRITE);
  assign data_byte = hold_q;
`endif

  assign handshake  = bus.cmd_valid && (state == ST_IDLE);
  assign more_bytes = has_data && (byte_cnt != LEN9);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_data  = data_byte;
    tx_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (skip_spi) begin
            next_state = ST_DESEL;
          end else begin
            load       = 1'b1;
            load_data  = cmd_byte(bus.cmd_op, bus.cmd_line);
            next_state = ST_SEL;
          end
        end
      end
      ST_SEL: begin
        if (wait_cnt == SEL_LAST) next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        tx_en = 1'b1;
        if (tx_byte_done) begin
          if (more_bytes) load = 1'b1;   // next byte starts with no SCK gap
          else            next_state = ST_DESEL;
        end
      end
      ST_DESEL: begin
        if (wait_cnt == GAP_LAST) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state != next_state) begin
      wait_cnt <= '0;
    end else if ((state == ST_SEL) || (state == ST_DESEL)) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= OSD_DISABLE;
      line_q   <= '0;
      byte_cnt <= '0;
      hold_q   <= '0;
      rd_q     <= 1'b0;
    end else begin
      if (handshake) begin
        op_q     <= bus.cmd_op;
        line_q   <= bus.cmd_line;
        byte_cnt <= '0;
      end else if ((state == ST_SHIFT) && load) begin
        byte_cnt <= byte_cnt + 9'd1;
      end
      // buffer returns data the cycle after the strobe; capture it then so it
      // is ready well before the end of the current byte
      rd_q <= bus.byte_rd;
      if (rd_q) hold_q <= bus.byte_data;
    end
  end

  // Prefetch the byte that follows the one now shifting; byte_cnt is the index
  // of that next byte (0 during the command byte).
  assign bus.byte_rd   = (state == ST_SHIFT) && (op_q == OSD_WRITE) && tx_last_low &&
                         (byte_cnt != LEN9);
  assign bus.byte_addr = {line_q, byte_cnt[7:0]};
  assign bus.cmd_ready = (state == ST_IDLE);

  osd_spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_byte_tx (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .en             (tx_en),
    .load           (load),
    .load_data      (load_data),
    .sck            (tx_sck),
    .di             (tx_di),
    .last_low_start (tx_last_low),
    .byte_done      (tx_byte_done)
  );

  // Outputs decode straight from registers so reset forces SS3 high and SCK low at once.
  assign SPI_SS3   = !((state == ST_SEL) || (state == ST_SHIFT));
  assign SPI_SCK   = (state == ST_SHIFT) && tx_sck;
  assign SPI_DI    = ((state == ST_SEL) || (state == ST_SHIFT)) && tx_di;
  assign done      = (state == ST_DESEL) && (wait_cnt == 16'd0);
  assign state_dbg = state;

endmodule
